coherence_bus_sequencer: RTL and testbench

- Parametrised successor to the single-requestor snoop bus request path.
- Arbitrates NUM_REQ cache controllers (I/D caches of all cores) onto one totally-ordered snoop bus, in round-robin or fixed-priority mode.
- Broadcasts one request at a time and holds the bus until the matching data response arrives, so the MSI/MESI protocol sees atomic transactions.
- A watchdog flags a response that never arrives.

---
 rtl/cache_types_pkg.sv | 27 ++
 rtl/coherence_rr_arbiter.sv | 42 ++++
 rtl/coherence_bus_sequencer.sv | 154 +++++++++++++++
 tb/tb_coherence_bus_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared cache/bus types: snoop transaction encoding, sequencer states, arbitration modes.
package cache_types;

  // Sized snoop bus transaction encoding.
  typedef enum logic [1:0] {
    GETS  = 2'd0,
    GETM  = 2'd1,
    PUTM  = 2'd2,
    NOREQ = 2'd3
  } bus_tx_enc_t;

  // Bus sequencer FSM states.
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_BCAST = 2'd1,
    SEQ_WAIT  = 2'd2
  } seq_state_t;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Bits needed to index n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coherence_rr_arbiter.sv
// Request arbiter: round-robin from a pointer, or fixed priority (lowest index wins).
module coherence_rr_arbiter
  import cache_types::*;
#(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned IDX_W    = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               any_c,
  output logic [IDX_W-1:0]   next_ptr_c
);

  // Scan candidates in priority order; the first asserted one wins.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ARB_MODE == ARB_FIXED) begin
        cand = k;
      end else begin
        cand = (32'(ptr) + k) % NUM_REQ;
      end
      if (!any_c && req[IDX_W'(cand)]) begin
        any_c       = 1'b1;
        grant_idx_c = IDX_W'(cand);
      end
    end
  end

  // One-hot grant and the pointer value following the winner.
  always_comb begin
    grant_c    = any_c ? (NUM_REQ'(1) << grant_idx_c) : '0;
    next_ptr_c = (grant_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + 1'b1;
  end

endmodule

// File: rtl/coherence_bus_sequencer.sv
// Serialises cache-controller requests onto one snoop bus, holding it until the data response.
module coherence_bus_sequencer
  import cache_types::*;
#(
  parameter int unsigned NUM_REQ        = 8,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned SRC_W          = $clog2(NUM_REQ) + 1,
  parameter int unsigned ARB_MODE       = ARB_RR,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*2-1:0]      req_tx,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      bus_valid,
  output logic [SRC_W-1:0]          bus_source,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [1:0]                bus_tx,
  input  logic                      resp_valid,
  input  logic [SRC_W-1:0]          resp_destination,
  input  logic [ADDR_W-1:0]         resp_addr,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned WD_W  = idx_width(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  seq_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [SRC_W-1:0]   lat_src_q;
  logic [ADDR_W-1:0]  lat_addr_q;
  bus_tx_enc_t        lat_tx_q;

  logic [NUM_REQ-1:0] grant_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic [IDX_W-1:0]   next_ptr_c;
  logic               any_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  bus_tx_enc_t        sel_tx_c;
  logic               idle_c;
  logic               load_c;
  logic               err_set_c;
  logic               resp_match_c;

  coherence_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ARB_MODE (ARB_MODE),
    .IDX_W    (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .any_c       (any_c),
    .next_ptr_c  (next_ptr_c)
  );

  // Winner's payload, grant visibility and response matching against the latched request.
  always_comb begin
    idle_c       = rst_n && (state_q == SEQ_IDLE);
    req_ready    = idle_c ? grant_c : '0;
    sel_addr_c   = req_addr[32'(grant_idx_c) * ADDR_W +: ADDR_W];
    sel_tx_c     = bus_tx_enc_t'(req_tx[32'(grant_idx_c) * 2 +: 2]);
    resp_match_c = resp_valid && (resp_destination == lat_src_q) && (resp_addr == lat_addr_q);
  end

  // Next-state logic: grant in idle, one broadcast cycle, then wait for the matching response.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    wd_d      = wd_q;
    load_c    = 1'b0;
    err_set_c = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (any_c) begin
          if (ARB_MODE == ARB_RR) begin
            rr_ptr_d = next_ptr_c;
          end
          // A NOREQ grant consumes the slot without touching the bus.
          if (sel_tx_c != NOREQ) begin
            load_c  = 1'b1;
            state_d = SEQ_BCAST;
          end
        end
      end
      SEQ_BCAST: begin
        if ((lat_tx_q == PUTM) || resp_match_c) begin
          state_d = SEQ_IDLE;
        end else begin
          state_d = SEQ_WAIT;
          wd_d    = '0;
        end
      end
      SEQ_WAIT: begin
        // A matching response beats the watchdog in the same cycle.
        if (resp_match_c) begin
          state_d = SEQ_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
          err_set_c = 1'b1;
          state_d   = SEQ_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // State, pointer, watchdog, request latch and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      rr_ptr_q    <= '0;
      wd_q        <= '0;
      lat_src_q   <= '0;
      lat_addr_q  <= '0;
      lat_tx_q    <= GETS;
      bus_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_q      <= wd_d;
      bus_valid <= (state_d == SEQ_BCAST);
      busy      <= (state_d != SEQ_IDLE);
      if (load_c) begin
        lat_src_q  <= SRC_W'(grant_idx_c);
        lat_addr_q <= sel_addr_c;
        lat_tx_q   <= sel_tx_c;
      end
      if (err_set_c) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Broadcast fields come straight from the latch and hold between broadcasts.
  always_comb begin
    bus_source = lat_src_q;
    bus_addr   = lat_addr_q;
    bus_tx     = lat_tx_q;
  end

endmodule

// File: tb/tb_coherence_bus_sequencer.sv
// Self-checking bench for coherence_bus_sequencer: directed scenarios plus randomized traffic.
module tb_coherence_bus_sequencer;
  import cache_types::*;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [2*N-1:0]    req_tx;
  logic              resp_valid;
  logic [SW-1:0]     resp_destination;
  logic [AW-1:0]     resp_addr;

  logic [N-1:0]  rdy, rdy_fx, rdy_lt;
  logic          bv, bv_fx, bv_lt;
  logic [SW-1:0] bsrc, bsrc_fx, bsrc_lt;
  logic [AW-1:0] baddr, baddr_fx, baddr_lt;
  logic [1:0]    btx, btx_fx, btx_lt;
  logic          busy, busy_fx, busy_lt;
  logic          terr, terr_fx, terr_lt;

  int total = 0;
  int bad   = 0;

  // Round-robin, short watchdog: main instance.
  coherence_bus_sequencer #(.NUM_REQ(N), .ADDR_W(AW), .SRC_W(SW), .ARB_MODE(ARB_RR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_tx(req_tx),
    .req_ready(rdy), .bus_valid(bv), .bus_source(bsrc), .bus_addr(baddr), .bus_tx(btx),
    .resp_valid(resp_valid), .resp_destination(resp_destination), .resp_addr(resp_addr),
    .busy(busy), .timeout_err(terr));

  // Fixed-priority instance.
  coherence_bus_sequencer #(.NUM_REQ(N), .ADDR_W(AW), .SRC_W(SW), .ARB_MODE(ARB_FIXED), .TIMEOUT_CYCLES(TO)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_tx(req_tx),
    .req_ready(rdy_fx), .bus_valid(bv_fx), .bus_source(bsrc_fx), .bus_addr(baddr_fx), .bus_tx(btx_fx),
    .resp_valid(resp_valid), .resp_destination(resp_destination), .resp_addr(resp_addr),
    .busy(busy_fx), .timeout_err(terr_fx));

  // Round-robin, long watchdog instance.
  coherence_bus_sequencer #(.NUM_REQ(N), .ADDR_W(AW), .SRC_W(SW), .ARB_MODE(ARB_RR), .TIMEOUT_CYCLES(255)) dut_lt (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_tx(req_tx),
    .req_ready(rdy_lt), .bus_valid(bv_lt), .bus_source(bsrc_lt), .bus_addr(baddr_lt), .bus_tx(btx_lt),
    .resp_valid(resp_valid), .resp_destination(resp_destination), .resp_addr(resp_addr),
    .busy(busy_lt), .timeout_err(terr_lt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [1:0] tx, input logic [AW-1:0] a);
    req_valid[p]          = v;
    req_tx[p*2 +: 2]      = tx;
    req_addr[p*AW +: AW]  = a;
  endtask

  task automatic set_resp(input logic v, input logic [SW-1:0] d, input logic [AW-1:0] a);
    resp_valid       = v;
    resp_destination = d;
    resp_addr        = a;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_addr  = '0;
    req_tx    = '0;
    set_resp(1'b0, '0, '0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (rdy !== 8'h00) begin bad++; $display("FAIL reset_ready got=%h want=00", rdy); end
      total++; if ({bv, busy, terr} !== 3'b000) begin bad++; $display("FAIL reset_status bv/busy/terr got=%b want=000", {bv, busy, terr}); end
      total++; if ({bsrc, baddr, btx} !== '0) begin bad++; $display("FAIL reset_bus src=%h addr=%h tx=%h want 0", bsrc, baddr, btx); end
    end
    rst_n = 1'b1;
    #1;
    total++; if (rdy !== 8'h01) begin bad++; $display("FAIL reset_first_grant got=%h want=01", rdy); end
  endtask

  task automatic test_rr_fairness();
    logic [N-1:0] exp_r;
    do_reset();
    for (int i = 0; i < N; i++) set_port(i, 1'b1, PUTM, AW'(32'h100 * i));
    for (int g = 0; g < 9; g++) begin
      #1;
      exp_r = N'(1) << (g % N);
      total++; if (rdy !== exp_r) begin bad++; $display("FAIL rr_grant[%0d] got=%h want=%h", g, rdy, exp_r); end
      total++; if (bv !== 1'b0) begin bad++; $display("FAIL rr_idle_bv[%0d] got=%b want=0", g, bv); end
      total++; if (rdy_fx !== 8'h01) begin bad++; $display("FAIL fixed_grant[%0d] got=%h want=01", g, rdy_fx); end
      step();
      total++; if ({bv, bsrc, baddr, btx} !== {1'b1, SW'(g % N), AW'(32'h100 * (g % N)), PUTM}) begin
        bad++; $display("FAIL rr_bcast[%0d] got v=%b src=%0d addr=%h tx=%0d want src=%0d", g, bv, bsrc, baddr, btx, g % N);
      end
      total++; if ({bv_fx, bsrc_fx} !== {1'b1, SW'(0)}) begin bad++; $display("FAIL fixed_bcast[%0d] got v=%b src=%0d want 1/0", g, bv_fx, bsrc_fx); end
      step();
    end
  endtask

  task automatic test_get_wait();
    do_reset();
    set_port(3, 1'b1, GETM, 32'h40);
    #1;
    total++; if (rdy_lt !== 8'h08) begin bad++; $display("FAIL get_grant got=%h want=08", rdy_lt); end
    step();                                            // T+1
    set_port(3, 1'b0, GETS, '0);
    set_port(5, 1'b1, GETS, 32'h80);
    total++; if ({bv_lt, bsrc_lt, baddr_lt, btx_lt, busy_lt} !== {1'b1, SW'(3), AW'(32'h40), GETM, 1'b1}) begin
      bad++; $display("FAIL get_bcast got v=%b src=%0d addr=%h tx=%0d busy=%b", bv_lt, bsrc_lt, baddr_lt, btx_lt, busy_lt);
    end
    step();                                            // T+2
    set_resp(1'b1, 4'd2, 32'h40);
    step();                                            // T+3
    set_resp(1'b1, 4'd3, 32'h44);
    step();                                            // T+4
    set_resp(1'b0, '0, '0);
    step();                                            // T+5
    total++; if ({busy_lt, bv_lt, rdy_lt} !== {1'b1, 1'b0, 8'h00}) begin
      bad++; $display("FAIL get_hold got busy=%b bv=%b rdy=%h want 1/0/00", busy_lt, bv_lt, rdy_lt);
    end
    step();                                            // T+6
    set_resp(1'b1, 4'd3, 32'h40);
    #1;
    total++; if (busy_lt !== 1'b1) begin bad++; $display("FAIL get_busy_at_resp got=%b want=1", busy_lt); end
    step();                                            // T+7
    set_resp(1'b0, '0, '0);
    #1;
    total++; if ({busy_lt, rdy_lt} !== {1'b0, 8'h20}) begin bad++; $display("FAIL get_next_grant got busy=%b rdy=%h want 0/20", busy_lt, rdy_lt); end
    step();                                            // T+8
    total++; if ({bv_lt, bsrc_lt, baddr_lt} !== {1'b1, SW'(5), AW'(32'h80)}) begin
      bad++; $display("FAIL get_next_bcast got v=%b src=%0d addr=%h", bv_lt, bsrc_lt, baddr_lt);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_port(2, 1'b1, GETS, 32'h20);
    #1;
    total++; if (rdy !== 8'h04) begin bad++; $display("FAIL same_grant got=%h want=04", rdy); end
    step();
    set_port(2, 1'b0, GETS, '0);
    set_port(6, 1'b1, PUTM, 32'h60);
    set_resp(1'b1, 4'd2, 32'h20);
    #1;
    total++; if (bv !== 1'b1) begin bad++; $display("FAIL same_bcast got=%b want=1", bv); end
    step();
    set_resp(1'b0, '0, '0);
    #1;
    total++; if ({busy, rdy} !== {1'b0, 8'h40}) begin bad++; $display("FAIL same_idle got busy=%b rdy=%h want 0/40", busy, rdy); end
    step();
    total++; if ({bv, bsrc} !== {1'b1, SW'(6)}) begin bad++; $display("FAIL same_next got v=%b src=%0d want 1/6", bv, bsrc); end
  endtask

  task automatic test_watchdog();
    do_reset();
    set_port(0, 1'b1, GETS, 32'h10);
    #1;
    total++; if (rdy !== 8'h01) begin bad++; $display("FAIL wd_grant got=%h want=01", rdy); end
    step();
    set_port(0, 1'b0, GETS, '0);
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if ({busy, terr} !== 2'b10) begin bad++; $display("FAIL wd_wait[%0d] got busy=%b err=%b want 1/0", k, busy, terr); end
    end
    step();
    total++; if ({busy, terr} !== 2'b01) begin bad++; $display("FAIL wd_expire got busy=%b err=%b want 0/1", busy, terr); end
    set_port(4, 1'b1, PUTM, 32'h44);
    #1;
    total++; if (rdy !== 8'h10) begin bad++; $display("FAIL wd_after_grant got=%h want=10", rdy); end
    step();
    set_port(4, 1'b0, PUTM, '0);
    step();
    total++; if ({busy, terr} !== 2'b01) begin bad++; $display("FAIL wd_sticky got busy=%b err=%b want 0/1", busy, terr); end

    do_reset();
    #1;
    total++; if (terr !== 1'b0) begin bad++; $display("FAIL wd_reset_clear got=%b want=0", terr); end
    set_port(1, 1'b1, GETM, 32'h18);
    step();                                            // BCAST
    set_port(1, 1'b0, GETS, '0);
    for (int k = 1; k <= 4; k++) step();               // now in 4th wait cycle
    set_resp(1'b1, 4'd1, 32'h18);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wd_edge_busy got=%b want=1", busy); end
    step();
    set_resp(1'b0, '0, '0);
    total++; if ({busy, terr} !== 2'b00) begin bad++; $display("FAIL wd_edge_resp got busy=%b err=%b want 0/0", busy, terr); end
  endtask

  task automatic test_noreq_reset();
    do_reset();
    set_port(1, 1'b1, NOREQ, 32'h11);
    #1;
    total++; if (rdy !== 8'h02) begin bad++; $display("FAIL noreq_grant got=%h want=02", rdy); end
    step();
    set_port(1, 1'b0, GETS, '0);
    total++; if ({bv, busy} !== 2'b00) begin bad++; $display("FAIL noreq_nobus got bv=%b busy=%b want 0/0", bv, busy); end
    set_port(0, 1'b1, GETM, 32'hA0);
    set_port(2, 1'b1, GETM, 32'hA2);
    #1;
    total++; if (rdy !== 8'h04) begin bad++; $display("FAIL noreq_ptr got=%h want=04", rdy); end
    step();
    set_port(2, 1'b0, GETS, '0);
    total++; if ({bv, bsrc} !== {1'b1, SW'(2)}) begin bad++; $display("FAIL noreq_bcast got v=%b src=%0d want 1/2", bv, bsrc); end
    step();
    rst_n = 1'b0;
    step();
    total++; if ({rdy, bv, busy, terr, bsrc, baddr, btx} !== '0) begin
      bad++; $display("FAIL midreset got rdy=%h bv=%b busy=%b err=%b src=%0d addr=%h tx=%0d want all 0", rdy, bv, busy, terr, bsrc, baddr, btx);
    end
    rst_n = 1'b1;
    set_port(7, 1'b1, PUTM, 32'hF0);
    #1;
    total++; if (rdy !== 8'h01) begin bad++; $display("FAIL midreset_ptr got=%h want=01", rdy); end
  endtask

  task automatic test_random();
    bit          pend[N];
    logic [1:0]  ptx[N];
    logic [AW-1:0] paddr[N];
    int          ptr;
    bit          terr_m;
    int          w;
    int          d;
    bit          any;
    do_reset();
    ptr = 0;
    terr_m = 1'b0;
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    for (int t = 0; t < 150; t++) begin
      any = 1'b0;
      for (int p = 0; p < N; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1; ptx[p] = 2'($urandom_range(0, 3)); paddr[p] = $urandom;
          set_port(p, 1'b1, ptx[p], paddr[p]);
        end
        any |= pend[p];
      end
      if (!any) begin
        w = int'($urandom_range(0, N - 1));
        pend[w] = 1'b1; ptx[w] = 2'($urandom_range(0, 3)); paddr[w] = $urandom;
        set_port(w, 1'b1, ptx[w], paddr[w]);
      end
      #1;
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
      total++; if (rdy !== (N'(1) << w)) begin bad++; $display("FAIL rnd_grant[%0d] got=%h want port %0d", t, rdy, w); end
      total++; if ({busy, terr} !== {1'b0, terr_m}) begin bad++; $display("FAIL rnd_idle[%0d] got busy=%b err=%b want 0/%b", t, busy, terr, terr_m); end
      step();
      pend[w] = 1'b0;
      set_port(w, 1'b0, GETS, '0);
      ptr = (w + 1) % N;
      if (ptx[w] == NOREQ) begin
        total++; if ({bv, busy} !== 2'b00) begin bad++; $display("FAIL rnd_noreq[%0d] got bv=%b busy=%b", t, bv, busy); end
        continue;
      end
      total++; if ({bv, bsrc, baddr, btx} !== {1'b1, SW'(w), paddr[w], ptx[w]}) begin
        bad++; $display("FAIL rnd_bcast[%0d] got v=%b src=%0d addr=%h tx=%0d want src=%0d addr=%h tx=%0d", t, bv, bsrc, baddr, btx, w, paddr[w], ptx[w]);
      end
      if (ptx[w] == PUTM) begin
        step();
        continue;
      end
      d = int'($urandom_range(0, 6));
      for (int k = 0; k <= int'(TO); k++) begin
        if (k == d) set_resp(1'b1, SW'(w), paddr[w]);
        else if ($urandom_range(0, 1) == 1) set_resp(1'b1, SW'((w + 1 + int'($urandom_range(0, 6))) % N), paddr[w]);
        else set_resp(1'b1, SW'(w), paddr[w] ^ 32'h4);
        #1;
        total++; if ({busy, rdy} !== {1'b1, 8'h00}) begin bad++; $display("FAIL rnd_busy[%0d.%0d] got busy=%b rdy=%h want 1/00", t, k, busy, rdy); end
        step();
        set_resp(1'b0, '0, '0);
        if (k == d) break;
        if (k == int'(TO)) begin
          terr_m = 1'b1;
          break;
        end
      end
    end
    #1;
    total++; if ({busy, terr} !== {1'b0, terr_m}) begin bad++; $display("FAIL rnd_final got busy=%b err=%b want 0/%b", busy, terr, terr_m); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_tx = '0;
    set_resp(1'b0, '0, '0);
    test_reset();
    test_rr_fairness();
    test_get_wait();
    test_same_cycle();
    test_watchdog();
    test_noreq_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
